// File: rtl/cp0_unit.sv
// CP0 coprocessor: Count/Compare timer, Status, Cause, EPC and the
// user/kernel mode FSM, with a decode-stage read port and write bypass.
module cp0_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_c0W,
  input  logic [4:0]  writeregW,
  input  logic [31:0] resultW,
  input  logic [4:0]  rtD,
  output logic [31:0] c0D,
  input  logic [31:0] pcF,
  input  logic [2:0]  int_cause,
  input  logic        cause_write,
  input  logic        exit_kernel,
  output logic        kernel_mode,
  output logic        timer_irq
);

  localparam logic [0:0] USER   = 1'b0;
  localparam logic [0:0] KERNEL = 1'b1;

  localparam logic [4:0] R_COUNT   = 5'd9;
  localparam logic [4:0] R_COMPARE = 5'd11;
  localparam logic [4:0] R_STATUS  = 5'd12;
  localparam logic [4:0] R_CAUSE   = 5'd13;
  localparam logic [4:0] R_EPC     = 5'd14;

  logic [0:0]  r_state;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ie;
  logic [31:0] r_epc;
  logic [2:0]  r_exc;
  logic        r_nested;
  logic        r_pend;
  logic        r_irq;

  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic        w_wr_cause;
  logic        w_wr_epc;
  logic        w_enter;
  logic        w_nest;
  logic        w_leave;
  logic        w_match;
  logic        w_byp;
  logic [31:0] w_cause;

  assign w_wr_count   = write_c0W && (writeregW == R_COUNT);
  assign w_wr_compare = write_c0W && (writeregW == R_COMPARE);
  assign w_wr_status  = write_c0W && (writeregW == R_STATUS);
  assign w_wr_cause   = write_c0W && (writeregW == R_CAUSE);
  assign w_wr_epc     = write_c0W && (writeregW == R_EPC);

  assign w_enter = (r_state == USER) && cause_write;
  assign w_leave = (r_state == KERNEL) && exit_kernel;
  assign w_nest  = (r_state == KERNEL) && cause_write && !exit_kernel;
  assign w_match = (r_count == r_compare) && (r_compare != 32'd0);

  assign w_cause = {r_nested, 15'd0, r_pend, 10'd0, r_exc, 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= USER;
    end else if (w_enter) begin
      r_state <= KERNEL;
    end else if (w_leave) begin
      r_state <= USER;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_ie      <= 1'b0;
      r_epc     <= 32'd0;
      r_exc     <= 3'd0;
      r_nested  <= 1'b0;
      r_pend    <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_count <= w_wr_count ? resultW : r_count + 32'd1;
      if (w_wr_compare) r_compare <= resultW;
      if (w_wr_status)  r_ie <= resultW[0];
      // exception capture takes priority over a software EPC write
      if (w_enter)       r_epc <= pcF;
      else if (w_wr_epc) r_epc <= resultW;
      if (w_enter) r_exc <= int_cause;
      if (w_nest)          r_nested <= 1'b1;
      else if (w_wr_cause) r_nested <= 1'b0;
      if (w_wr_compare) r_pend <= 1'b0;
      else if (w_match) r_pend <= 1'b1;
      r_irq <= r_pend && r_ie && (r_state == USER);
    end
  end

  assign w_byp = write_c0W && (writeregW == rtD);

  always_comb begin
    c0D = 32'd0;
    unique case (rtD)
      R_COUNT:   c0D = w_byp ? resultW : r_count;
      R_COMPARE: c0D = w_byp ? resultW : r_compare;
      R_STATUS:  c0D = {30'd0, r_state, w_byp ? resultW[0] : r_ie};
      R_CAUSE:   c0D = w_cause;
      R_EPC:     c0D = w_byp ? resultW : r_epc;
      default:   c0D = 32'd0;
    endcase
  end

  assign kernel_mode = r_state;
  assign timer_irq   = r_irq;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed scenarios plus random traffic, all
// checked against a behavioural register-file model.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_c0W;
  logic [4:0]  writeregW;
  logic [31:0] resultW;
  logic [4:0]  rtD;
  logic [31:0] c0D;
  logic [31:0] pcF;
  logic [2:0]  int_cause;
  logic        cause_write;
  logic        exit_kernel;
  logic        kernel_mode;
  logic        timer_irq;

  int n_cmp = 0;
  int n_bad = 0;

  bit          m_k;
  bit [31:0]   m_count;
  bit [31:0]   m_cmp;
  bit          m_ie;
  bit [31:0]   m_epc;
  bit [2:0]    m_exc;
  bit          m_nest;
  bit          m_pend;
  bit          m_irq;

  cp0_unit dut (
    .clk(clk), .reset(reset),
    .write_c0W(write_c0W), .writeregW(writeregW),
    .resultW(resultW), .rtD(rtD), .c0D(c0D),
    .pcF(pcF), .int_cause(int_cause),
    .cause_write(cause_write), .exit_kernel(exit_kernel),
    .kernel_mode(kernel_mode), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] m_cause();
    return (32'(m_nest) << 31) + (32'(m_pend) << 15) +
           (32'(m_exc) << 2);
  endfunction

  function automatic bit [31:0] m_read(input bit [4:0] r);
    bit byp;
    byp = write_c0W && (writeregW == r);
    case (r)
      9:  return byp ? resultW : m_count;
      11: return byp ? resultW : m_cmp;
      12: return 32'(m_k) * 2 + 32'(byp ? resultW[0] : m_ie);
      13: return m_cause();
      14: return byp ? resultW : m_epc;
      default: return 0;
    endcase
  endfunction

  task automatic m_reset();
    m_k = 0; m_count = 0; m_cmp = 0; m_ie = 0; m_epc = 0;
    m_exc = 0; m_nest = 0; m_pend = 0; m_irq = 0;
  endtask

  // Apply one clock edge of the architectural rules to the model.
  task automatic m_edge();
    bit [31:0] cnt0, cmp0;
    bit k0, p0, ie0;
    bit wc, wcmp;
    if (reset) begin
      m_reset();
      return;
    end
    cnt0 = m_count; cmp0 = m_cmp; k0 = m_k; p0 = m_pend; ie0 = m_ie;
    wc = write_c0W; wcmp = wc && writeregW == 11;
    m_count = (wc && writeregW == 9) ? resultW : cnt0 + 1;
    if (wcmp) m_cmp = resultW;
    if (wc && writeregW == 12) m_ie = resultW[0];
    if (wc && writeregW == 13) m_nest = 0;
    if (wc && writeregW == 14) m_epc = resultW;
    if (!k0 && cause_write) begin
      m_k = 1; m_epc = pcF; m_exc = int_cause;
    end else if (k0 && exit_kernel) begin
      m_k = 0;
    end else if (k0 && cause_write) begin
      m_nest = 1;
    end
    if (wcmp) m_pend = 0;
    else if (cnt0 == cmp0 && cmp0 != 0) m_pend = 1;
    m_irq = p0 && ie0 && !k0;
  endtask

  task automatic step();
    #1;
    check($sformatf("c0D[r%0d]", rtD), c0D, m_read(rtD));
    check("kernel_mode", 32'(kernel_mode), 32'(m_k));
    check("timer_irq", 32'(timer_irq), 32'(m_irq));
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    write_c0W = 0; writeregW = 0; resultW = 0;
    cause_write = 0; exit_kernel = 0;
  endtask

  task automatic wr(input bit [4:0] r, input bit [31:0] v);
    idle();
    write_c0W = 1; writeregW = r; resultW = v;
    step();
  endtask

  task automatic rd(input string tag, input bit [4:0] r,
                    input bit [31:0] exp);
    idle();
    rtD = r;
    #1;
    check(tag, c0D, exp);
    step();
  endtask

  task automatic exc(input bit [31:0] pc, input bit [2:0] ic,
                     input bit ex);
    idle();
    cause_write = 1; pcF = pc; int_cause = ic; exit_kernel = ex;
    step();
  endtask

  int hit;
  bit [4:0] regs[9];

  initial begin
    regs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd1, 5'd10, 5'd31};
    idle();
    rtD = 0; pcF = 0; int_cause = 0;
    m_reset();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    rd("rst count", 9, 0);
    rd("rst compare", 11, 0);
    rd("rst status", 12, 0);
    rd("rst cause", 13, 0);
    rd("rst epc", 14, 0);
    reset = 0;

    exc(32'h40, 3'b101, 0);
    check("enter kmode", 32'(kernel_mode), 1);
    rd("enter epc", 14, 32'h40);
    rd("enter cause", 13, 32'h14);

    exc(32'h80, 3'b010, 0);
    rd("nest epc", 14, 32'h40);
    rd("nest cause", 13, 32'h8000_0014);
    idle(); exit_kernel = 1; step();
    check("exit kmode", 32'(kernel_mode), 0);
    wr(13, 32'hFFFF_FFFF);
    rd("cause clr31", 13, 32'h14);

    exc(32'h100, 3'b010, 0);
    exc(32'h200, 3'b111, 1);
    check("simul kmode", 32'(kernel_mode), 0);
    rd("simul epc", 14, 32'h100);
    rd("simul cause", 13, 32'h08);

    idle();
    write_c0W = 1; writeregW = 14; resultW = 32'h1234; rtD = 14;
    #1 check("byp epc", c0D, 32'h1234);
    step();
    idle();
    write_c0W = 1; writeregW = 13; resultW = 32'h5555; rtD = 13;
    #1 check("nobyp cause", c0D, 32'h08);
    step();

    wr(11, 5);
    wr(12, 1);
    wr(9, 0);
    hit = -1;
    for (int i = 0; i < 20 && hit < 0; i++) begin
      idle(); rtD = 13;
      #1;
      if (c0D[15]) hit = i;
      step();
    end
    check("pend latency", 32'(hit), 6);
    check("irq after pend", 32'(timer_irq), 1);
    wr(11, 100);
    idle(); rtD = 13; step();
    rd("pend clr", 13, 32'h08);
    check("irq clr", 32'(timer_irq), 0);

    wr(9, 32'hFFFF_FFFE);
    rd("wrap fe", 9, 32'hFFFF_FFFE);
    rd("wrap ff", 9, 32'hFFFF_FFFF);
    rd("wrap 00", 9, 32'h0);

    for (int i = 0; i < 400; i++) begin
      idle();
      write_c0W = ($urandom_range(0, 2) == 0);
      writeregW = regs[$urandom_range(0, 8)];
      resultW = $urandom;
      if (writeregW == 11 && $urandom_range(0, 1) == 1)
        resultW = m_count + $urandom_range(1, 4);
      if (writeregW == 12) resultW = resultW | 32'hFFFF_FFF0;
      rtD = ($urandom_range(0, 3) == 0) ? writeregW :
            regs[$urandom_range(0, 8)];
      cause_write = ($urandom_range(0, 7) == 0);
      exit_kernel = ($urandom_range(0, 7) == 0);
      pcF = $urandom;
      int_cause = 3'($urandom);
      if (i == 250) begin
        #2 reset = 1;
        #1;
        check("async kmode", 32'(kernel_mode), 0);
        check("async irq", 32'(timer_irq), 0);
        m_reset();
        @(negedge clk);
        reset = 0;
      end else begin
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high; all state cleared immediately on assertion.
REQ-003 SHALL have port write_c0W, input, 1 bit: writeback-stage CP0 write enable.
REQ-004 SHALL have port writeregW, input, 5 bits: CP0 register number to write.
REQ-005 SHALL have port resultW, input, 32 bits: CP0 write data.
REQ-006 SHALL have port rtD, input, 5 bits: CP0 register number to read in decode.
REQ-007 SHALL have port c0D, output, 32 bits: combinational read data.
REQ-008 SHALL have port pcF, input, 32 bits: fetch PC, captured as the exception return address.
REQ-009 SHALL have port int_cause, input, 3 bits: exception code from the controller.
REQ-010 SHALL have port cause_write, input, 1 bit: exception-entry request from the controller.
REQ-011 SHALL have port exit_kernel, input, 1 bit: exception-return request from the controller.
REQ-012 SHALL have port kernel_mode, output, 1 bit: registered kernel/exception mode flag.
REQ-013 SHALL have port timer_irq, output, 1 bit: registered timer interrupt request.

Function
REQ-014 SHALL use a two-state FSM with states USER (kernel_mode=0) and KERNEL (kernel_mode=1).
REQ-015 USER state with cause_write=1: next state KERNEL, EPC<=pcF, Cause[4:2]<=int_cause, all at the same posedge.
REQ-016 KERNEL state with cause_write=1 and exit_kernel=0: state, EPC and Cause[4:2] unchanged; sticky Cause[31] (nested fault) <=1.
REQ-017 KERNEL state with exit_kernel=1: next state USER; any cause_write in the same cycle is ignored, including Cause[31].
REQ-018 USER state with exit_kernel=1 and cause_write=0: no effect.
REQ-019 Register map (number: behaviour):
- 9 Count: 32-bit counter; +1 every cycle; wraps 0xFFFFFFFF->0.
- 11 Compare: read/write.
- 12 Status: bit0 IE is R/W; bit1 reads kernel_mode and ignores writes; other bits read 0.
- 13 Cause: bit15 timer pending, bits[4:2] exccode, bit31 nested fault; any write clears bit31 only.
- 14 EPC: read/write.
- All other numbers read 0 and ignore writes.
REQ-020 A CP0 write (write_c0W=1) SHALL update the selected register at posedge; a Count write loads resultW instead of incrementing that cycle.
REQ-021 An EPC write SHALL lose to a same-cycle exception capture (REQ-015).
REQ-022 Timer pending SHALL set 1 cycle after Count==Compare with Compare!=0.
REQ-023 Timer pending SHALL clear on any write to Compare; that write wins over a same-cycle set.
REQ-024 timer_irq SHALL be registered, equal to pending & IE & ~kernel_mode of the previous cycle.
REQ-025 c0D SHALL be combinational from rtD.
REQ-026 c0D write bypass: when write_c0W=1 and writeregW==rtD, c0D SHALL show resultW for registers 9, 11 and 14.
REQ-027 c0D write bypass for register 12: c0D SHALL show {30'b0, kernel_mode, resultW[0]}.
REQ-028 Register 13 and unmapped register numbers SHALL never be bypassed.

Reset
REQ-029 On reset SHALL set kernel_mode=0, timer_irq=0, and Count, Compare, Status, Cause, EPC all = 0.
REQ-030 Reset mid-exception or mid-count SHALL return to USER immediately; no state is retained.

Verification
REQ-031 Scenario (exception entry): USER, pcF=0x00000040, int_cause=3'b101, cause_write pulse -> next cycle kernel_mode=1, EPC=0x40, Cause=0x00000014.
REQ-032 Scenario (nested fault, then return): in KERNEL, cause_write with pcF=0x80 -> EPC stays 0x40, Cause[31]=1. Then exit_kernel -> kernel_mode=0. Then write Cause -> Cause[31]=0.
REQ-033 Scenario (timer): write Compare=5, Status=1, Count=0 -> pending set when Count reaches 5, timer_irq=1 one cycle after pending. Then write Compare=100 -> pending=0, timer_irq=0 the following cycle.
REQ-034 Scenario (Count wrap): write Count=0xFFFFFFFE -> reads 0xFFFFFFFF, then 0x00000000 on subsequent cycles.
REQ-035 Scenario (simultaneous entry/exit): in KERNEL, cause_write=1 and exit_kernel=1 same cycle -> kernel_mode=0, EPC and Cause unchanged.
REQ-036 Scenario (bypass): write_c0W=1, writeregW=14, resultW=0x1234, rtD=14 -> c0D=0x1234 same cycle. Repeat with register 13 -> c0D shows the old Cause value.
